// File: rtl/column_bar_plotter_pkg.sv
// rtl/column_bar_plotter_pkg.sv - framebuffer geometry and plotter state encodings
package column_bar_plotter_pkg;

   localparam int FB_H_RES          = 640;
   localparam int FB_V_RES          = 480;
   localparam int FB_DATA_WIDTH     = 32;
   localparam int FB_ADDRESS_LENGTH = 14;

   // The pixel writer is busy for this many cycles after each pulse.
   localparam int WRITER_BUSY_CYCLES = 4;

   localparam int OFFSET_W = 5;
   localparam int COORD_W  = 10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4
   } plot_state_t;

   function automatic int words_per_row(input int h_res, input int data_width);
      return h_res / data_width;
   endfunction

   function automatic int bottom_row_base(input int h_res, input int v_res, input int data_width);
      return (v_res - 1) * words_per_row(h_res, data_width);
   endfunction

endpackage

// File: rtl/column_bar_plotter.sv
// rtl/column_bar_plotter.sv - turns one (x, height) bar command into paced bottom-up pixel writes
module column_bar_plotter
   import column_bar_plotter_pkg::*;
#(
   parameter int H_RES          = FB_H_RES,
   parameter int V_RES          = FB_V_RES,
   parameter int DATA_WIDTH     = FB_DATA_WIDTH,
   parameter int ADDRESS_LENGTH = FB_ADDRESS_LENGTH,
   parameter int ISSUE_GAP      = WRITER_BUSY_CYCLES
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [COORD_W-1:0]        cmd_x,
   input  logic [COORD_W-1:0]        cmd_height,
   output logic [ADDRESS_LENGTH-1:0] word_address,
   output logic [OFFSET_W-1:0]       bit_offset,
   output logic                      word_and_offset_valid,
   output logic                      done
);

   localparam int GAP_W = $clog2(ISSUE_GAP);

   localparam logic [ADDRESS_LENGTH-1:0] ROW_BASE =
      ADDRESS_LENGTH'(bottom_row_base(H_RES, V_RES, DATA_WIDTH));
   localparam logic [ADDRESS_LENGTH-1:0] ROW_STEP =
      ADDRESS_LENGTH'(words_per_row(H_RES, DATA_WIDTH));
   localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(ISSUE_GAP - 2);
   localparam logic [COORD_W:0]   X_LIMIT  = (COORD_W + 1)'(H_RES);
   localparam logic [COORD_W-1:0] Y_LIMIT  = COORD_W'(V_RES);

   plot_state_t state, state_nx;

   logic [COORD_W-1:0] x_q;
   logic [COORD_W-1:0] hc_q;
   logic [COORD_W-1:0] remaining;
   logic [GAP_W-1:0]   gap_cnt;
   logic               skip_column;

   assign skip_column = ({1'b0, x_q} >= X_LIMIT) || (hc_q == '0);

   assign cmd_ready             = (state == ST_IDLE);
   assign word_and_offset_valid = (state == ST_ISSUE);
   assign done                  = (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (cmd_valid) state_nx = ST_SETUP;
         ST_SETUP: state_nx = skip_column ? ST_DONE : ST_ISSUE;
         ST_ISSUE: state_nx = ST_WAIT;
         ST_WAIT: begin
            if (gap_cnt == '0) begin
               state_nx = (remaining == '0) ? ST_DONE : ST_ISSUE;
            end
         end
         ST_DONE:  state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // Address walks upward by one row per pixel; hc never exceeds V_RES so it stops at row 0.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         x_q          <= '0;
         hc_q         <= '0;
         remaining    <= '0;
         gap_cnt      <= '0;
         word_address <= '0;
         bit_offset   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  x_q  <= cmd_x;
                  hc_q <= (cmd_height > Y_LIMIT) ? Y_LIMIT : cmd_height;
               end
            end
            ST_SETUP: begin
               if (!skip_column) begin
                  word_address <= ROW_BASE + ADDRESS_LENGTH'(x_q[COORD_W-1:OFFSET_W]);
                  bit_offset   <= x_q[OFFSET_W-1:0];
                  remaining    <= hc_q;
               end
            end
            ST_ISSUE: begin
               remaining <= remaining - 1'b1;
               gap_cnt   <= GAP_LOAD;
            end
            ST_WAIT: begin
               if (gap_cnt != '0) begin
                  gap_cnt <= gap_cnt - 1'b1;
               end else if (remaining != '0) begin
                  word_address <= word_address - ROW_STEP;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_column_bar_plotter.sv
// tb/tb_column_bar_plotter.sv - directed bench for column_bar_plotter
module tb_column_bar_plotter;

   logic        clk;
   logic        resetn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [9:0]  cmd_x;
   logic [9:0]  cmd_height;
   logic [13:0] word_address;
   logic [4:0]  bit_offset;
   logic        word_and_offset_valid;
   logic        done;

   int tests    = 0;
   int failures = 0;

   int cyc      = 0;
   int abs_cyc  = 0;
   int last_pulse_abs = -1000;
   int gap_viol = 0;
   int ready_viol = 0;
   int pulse_cyc[$];
   int pulse_addr[$];
   int pulse_off[$];
   int done_cyc[$];

   column_bar_plotter dut (
      .clk                   (clk),
      .resetn                (resetn),
      .cmd_valid             (cmd_valid),
      .cmd_ready             (cmd_ready),
      .cmd_x                 (cmd_x),
      .cmd_height            (cmd_height),
      .word_address          (word_address),
      .bit_offset            (bit_offset),
      .word_and_offset_valid (word_and_offset_valid),
      .done                  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp_v);
      tests++;
      assert (obs === exp_v)
      else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic clear_log();
      pulse_cyc.delete();
      pulse_addr.delete();
      pulse_off.delete();
      done_cyc.delete();
      cyc = 0;
   endtask

   // Advance one cycle and sample outputs 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      abs_cyc++;
      if (word_and_offset_valid === 1'b1) begin
         if (abs_cyc - last_pulse_abs < 4) gap_viol++;
         last_pulse_abs = abs_cyc;
         pulse_cyc.push_back(cyc);
         pulse_addr.push_back(int'(word_address));
         pulse_off.push_back(int'(bit_offset));
      end
      if (done === 1'b1) done_cyc.push_back(cyc);
   endtask

   // Issue one command and follow it to done; cyc counts cycles after the accept edge.
   task automatic run_cmd(input int x, input int h, input int budget);
      int guard;
      guard = 0;
      while (cmd_ready !== 1'b1 && guard < 20) begin
         step();
         guard++;
      end
      clear_log();
      cmd_x      = 10'(x);
      cmd_height = 10'(h);
      cmd_valid  = 1'b1;
      step();
      cmd_valid  = 1'b0;
      if (cmd_ready !== 1'b0) ready_viol++;
      while (done_cyc.size() == 0 && cyc < budget) begin
         step();
         if (cmd_ready !== 1'b0) ready_viol++;
      end
   endtask

   initial begin
      resetn     = 1'b0;
      cmd_valid  = 1'b0;
      cmd_x      = '0;
      cmd_height = '0;

      // Reset held three cycles
      step(); step(); step();
      check("rst_valid", int'(word_and_offset_valid), 0);
      check("rst_done", int'(done), 0);
      check("rst_addr", int'(word_address), 0);
      check("rst_off", int'(bit_offset), 0);
      resetn = 1'b1;
      step();
      check("rst_ready_after", int'(cmd_ready), 1);

      // x=37 h=3
      run_cmd(37, 3, 40);
      check("basic_pulses", pulse_cyc.size(), 3);
      if (pulse_cyc.size() == 3) begin
         check("basic_c0", pulse_cyc[0], 2);
         check("basic_c1", pulse_cyc[1], 6);
         check("basic_c2", pulse_cyc[2], 10);
         check("basic_a0", pulse_addr[0], 9581);
         check("basic_a1", pulse_addr[1], 9561);
         check("basic_a2", pulse_addr[2], 9541);
         check("basic_o0", pulse_off[0], 5);
         check("basic_o2", pulse_off[2], 5);
      end
      check("basic_done", (done_cyc.size() > 0) ? done_cyc[0] : -1, 14);
      step();
      check("basic_ready_after", int'(cmd_ready), 1);

      // Zero height
      run_cmd(200, 0, 20);
      check("h0_pulses", pulse_cyc.size(), 0);
      check("h0_done", (done_cyc.size() > 0) ? done_cyc[0] : -1, 2);
      step();
      check("h0_ready_c3", int'(cmd_ready), 1);

      // Column off screen
      run_cmd(640, 7, 20);
      check("xoor_pulses", pulse_cyc.size(), 0);
      check("xoor_done", (done_cyc.size() > 0) ? done_cyc[0] : -1, 2);
      step();
      check("xoor_ready_c3", int'(cmd_ready), 1);

      // Height clamped to V_RES
      run_cmd(0, 600, 2100);
      check("clamp_pulses", pulse_cyc.size(), 480);
      if (pulse_cyc.size() > 0) begin
         check("clamp_first_addr", pulse_addr[0], 9580);
         check("clamp_last_addr", pulse_addr[pulse_addr.size()-1], 0);
         check("clamp_last_off", pulse_off[pulse_off.size()-1], 0);
         check("clamp_last_cyc", pulse_cyc[pulse_cyc.size()-1], 2 + 479*4);
      end
      check("clamp_done", (done_cyc.size() > 0) ? done_cyc[0] : -1, 1922);
      step();

      // Reset in cycle 7 of a height-5 command
      clear_log();
      cmd_x      = 10'd50;
      cmd_height = 10'd5;
      cmd_valid  = 1'b1;
      step();
      cmd_valid  = 1'b0;
      while (cyc < 7) step();
      resetn = 1'b0;
      step();
      check("midrst_valid", int'(word_and_offset_valid), 0);
      check("midrst_addr", int'(word_address), 0);
      check("midrst_ready", int'(cmd_ready), 1);
      step();
      resetn = 1'b1;
      check("midrst_pre_pulses", pulse_cyc.size(), 2);
      check("midrst_pre_done", done_cyc.size(), 0);
      repeat (30) step();
      check("midrst_post_pulses", pulse_cyc.size(), 2);
      check("midrst_post_done", done_cyc.size(), 0);
      run_cmd(100, 2, 30);
      check("after_rst_pulses", pulse_cyc.size(), 2);
      if (pulse_cyc.size() == 2) begin
         check("after_rst_a0", pulse_addr[0], 9583);
         check("after_rst_o0", pulse_off[0], 4);
         check("after_rst_a1", pulse_addr[1], 9563);
      end
      check("after_rst_done", (done_cyc.size() > 0) ? done_cyc[0] : -1, 10);
      step();

      // Back-to-back commands with cmd_valid held high
      clear_log();
      cmd_x      = 10'd31;
      cmd_height = 10'd1;
      cmd_valid  = 1'b1;
      while (cyc < 20) begin
         step();
         if (done === 1'b1 && done_cyc.size() == 1) cmd_x = 10'd32;
         if (cyc == 7) check("q_ready_idle", int'(cmd_ready), 1);
         if (cyc == 8) begin
            check("q_second_accepted", int'(cmd_ready), 0);
            cmd_valid = 1'b0;
         end
      end
      check("q_pulses", pulse_cyc.size(), 2);
      if (pulse_cyc.size() == 2) begin
         check("q_c0", pulse_cyc[0], 2);
         check("q_a0", pulse_addr[0], 9580);
         check("q_o0", pulse_off[0], 31);
         check("q_c1", pulse_cyc[1], 9);
         check("q_a1", pulse_addr[1], 9581);
         check("q_o1", pulse_off[1], 0);
      end
      check("q_dones", done_cyc.size(), 2);
      if (done_cyc.size() == 2) begin
         check("q_done0", done_cyc[0], 6);
         check("q_done1", done_cyc[1], 13);
      end

      check("pulse_spacing_violations", gap_viol, 0);
      check("ready_low_violations", ready_viol, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
